// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store initiator with word-split misaligned access
module load_store_unit #(
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_read_en,
   output logic        mem_write_en,
   output logic [3:0]  mem_byte_enable,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACC0, ACC1} state_t;

   state_t      state, state_next;
   logic        r_we;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr, r_wdata, lo_buf;

   function automatic logic [2:0] size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   // Fault decode works on the incoming request so a fault never leaves IDLE.
   logic [2:0] req_size;
   logic       req_illegal, req_misaligned, req_fault, accept, fault_accept;
   assign req_size       = size_of(req_funct3);
   assign req_illegal    = req_we ? (req_funct3 > 3'b010)
                                  : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
   assign req_misaligned = !ALLOW_MISALIGNED &&
                           ((req_size == 3'd2 && req_addr[0]) ||
                            (req_size == 3'd4 && req_addr[1:0] != 2'b00));
   assign req_fault      = req_illegal || req_misaligned;
   assign req_ready      = (state == IDLE) && !reset;
   assign accept         = req_valid && req_ready;
   assign fault_accept   = accept && req_fault;

   logic [2:0]  size;
   logic [1:0]  off;
   logic        crosses, finish_access;
   logic [7:0]  lane_mask;
   logic [63:0] lane_data;
   logic [31:0] hi_word, lo_word, window, load_result;

   assign size          = size_of(r_funct3);
   assign off           = r_addr[1:0];
   assign crosses       = ({2'b00, off} + {1'b0, size}) > 4'd4;
   assign lane_mask     = ((8'd1 << size) - 8'd1) << off;
   assign lane_data     = {32'b0, r_wdata} << {off, 3'b000};
   assign finish_access = (state == ACC0 && !crosses) || (state == ACC1);

   // In ACC1 the first word sits in lo_buf and the live read is the upper word.
   assign hi_word = (state == ACC1) ? mem_rdata : 32'b0;
   assign lo_word = (state == ACC1) ? lo_buf : mem_rdata;
   assign window  = 32'({hi_word, lo_word} >> {off, 3'b000});

   always_comb begin
      load_result = window;
      if (size == 3'd1)
         load_result = r_funct3[2] ? {24'b0, window[7:0]} : {{24{window[7]}}, window[7:0]};
      else if (size == 3'd2)
         load_result = r_funct3[2] ? {16'b0, window[15:0]} : {{16{window[15]}}, window[15:0]};
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         r_we     <= req_we;
         r_funct3 <= req_funct3;
         r_addr   <= req_addr;
         r_wdata  <= req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         resp_valid <= 1'b0;
         resp_rdata <= 32'b0;
         resp_fault <= 1'b0;
         lo_buf     <= 32'b0;
      end else begin
         state      <= state_next;
         resp_valid <= fault_accept || finish_access;
         if (state == ACC0)
            lo_buf <= mem_rdata;
         if (fault_accept) begin
            resp_fault <= 1'b1;
            resp_rdata <= 32'b0;
         end else if (finish_access) begin
            resp_fault <= 1'b0;
            resp_rdata <= r_we ? 32'b0 : load_result;
         end
      end
   end

   always_comb begin
      state_next      = state;
      mem_addr        = 32'b0;
      mem_wdata       = 32'b0;
      mem_read_en     = 1'b0;
      mem_write_en    = 1'b0;
      mem_byte_enable = 4'b0000;
      case (state)
         IDLE: begin
            if (accept && !req_fault)
               state_next = ACC0;
         end
         ACC0: begin
            mem_addr = {r_addr[31:2], 2'b00};
            if (r_we) begin
               mem_write_en    = 1'b1;
               mem_byte_enable = lane_mask[3:0];
               mem_wdata       = lane_data[31:0];
            end else begin
               mem_read_en     = 1'b1;
               mem_byte_enable = 4'b1111;
            end
            state_next = crosses ? ACC1 : IDLE;
         end
         ACC1: begin
            mem_addr = {r_addr[31:2] + 30'd1, 2'b00};
            if (r_we) begin
               mem_write_en    = 1'b1;
               mem_byte_enable = lane_mask[7:4];
               mem_wdata       = lane_data[63:32];
            end else begin
               mem_read_en     = 1'b1;
               mem_byte_enable = 4'b1111;
            end
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // Nothing may reach memory while reset is held, whatever state is registered.
      if (reset) begin
         mem_addr        = 32'b0;
         mem_wdata       = 32'b0;
         mem_read_en     = 1'b0;
         mem_write_en    = 1'b0;
         mem_byte_enable = 4'b0000;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized bench for load_store_unit against a byte-array memory model
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_clear = 1'b1;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b0;
   logic [31:0] req_addr = 32'b0, req_wdata = 32'b0;
   logic        req_valid_a = 1'b0, req_valid_s = 1'b0;

   logic        ready_a, rv_a, fault_a, mre_a, mwe_a;
   logic [31:0] rdata_a, maddr_a, mwdata_a, mrdata_a;
   logic [3:0]  mbe_a;
   logic        ready_s, rv_s, fault_s, mre_s, mwe_s;
   logic [31:0] rdata_s, maddr_s, mwdata_s, mrdata_s;
   logic [3:0]  mbe_s;

   logic [31:0] mem_a [0:255];
   logic [31:0] mem_s [0:255];
   logic [7:0]  ref_mem [0:1023];
   int          strobe_s = 0, wr24 = 0;
   int          n_checks = 0, n_errors = 0;

   int          obs_lat, acc_n;
   logic [31:0] obs_rdata;
   logic        obs_fault;
   logic [31:0] acc_addr [0:3];
   logic [31:0] acc_wd [0:3];
   logic [3:0]  acc_be [0:3];
   logic        acc_we [0:3];

   always #5 clk = ~clk;

   load_store_unit #(.ALLOW_MISALIGNED(1'b1)) u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid_a), .req_ready(ready_a),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(rv_a), .resp_rdata(rdata_a), .resp_fault(fault_a),
      .mem_addr(maddr_a), .mem_wdata(mwdata_a), .mem_read_en(mre_a), .mem_write_en(mwe_a),
      .mem_byte_enable(mbe_a), .mem_rdata(mrdata_a));

   load_store_unit #(.ALLOW_MISALIGNED(1'b0)) u_dut_strict (
      .clk(clk), .reset(reset), .req_valid(req_valid_s), .req_ready(ready_s),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(rv_s), .resp_rdata(rdata_s), .resp_fault(fault_s),
      .mem_addr(maddr_s), .mem_wdata(mwdata_s), .mem_read_en(mre_s), .mem_write_en(mwe_s),
      .mem_byte_enable(mbe_s), .mem_rdata(mrdata_s));

   assign mrdata_a = mem_a[maddr_a[9:2]];
   assign mrdata_s = mem_s[maddr_s[9:2]];

   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 256; i++) begin
            mem_a[i] <= 32'b0;
            mem_s[i] <= 32'b0;
         end
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (mwe_a && mbe_a[b]) mem_a[maddr_a[9:2]][8*b +: 8] <= mwdata_a[8*b +: 8];
            if (mwe_s && mbe_s[b]) mem_s[maddr_s[9:2]][8*b +: 8] <= mwdata_s[8*b +: 8];
         end
      end
      if (mre_s || mwe_s) strobe_s <= strobe_s + 1;
      if (mwe_a && maddr_a == 32'h24) wr24 <= wr24 + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: byte-addressed memory, 1024 bytes wrapping, RV32I load/store semantics.
   task automatic model(input bit allow, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic fault, output int lat);
      int size, off, idx;
      logic [31:0] v;
      size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      off   = int'(addr % 32'd4);
      fault = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      if (!allow && ((size == 2 && off % 2 == 1) || (size == 4 && off != 0))) fault = 1'b1;
      rdata = 32'b0;
      lat   = fault ? 1 : ((off + size > 4) ? 3 : 2);
      if (fault) return;
      v = 32'b0;
      for (int i = 0; i < size; i++) begin
         idx = int'((addr + 32'(i)) % 32'd1024);
         if (we) ref_mem[idx] = 8'(wdata >> (8 * i));
         else    v = v | (32'(ref_mem[idx]) << (8 * i));
      end
      if (!we) begin
         if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
         if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF_0000;
         rdata = v;
      end
   endtask

   task automatic run(input bit strict, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata);
      logic [31:0] e_rdata;
      logic        e_fault;
      int          e_lat;
      model(!strict, we, f3, addr, wdata, e_rdata, e_fault, e_lat);
      @(negedge clk);
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      if (strict) req_valid_s = 1'b1; else req_valid_a = 1'b1;
      check("req_ready", 64'(strict ? ready_s : ready_a), 64'(1));
      @(posedge clk); #1;
      req_valid_a = 1'b0; req_valid_s = 1'b0;
      acc_n = 0; obs_lat = 0; obs_rdata = 32'hX; obs_fault = 1'bX;
      for (int k = 1; k <= 6; k++) begin
         if (strict ? (mre_s || mwe_s) : (mre_a || mwe_a)) begin
            if (acc_n < 4) begin
               acc_addr[acc_n] = strict ? maddr_s : maddr_a;
               acc_wd[acc_n]   = strict ? mwdata_s : mwdata_a;
               acc_be[acc_n]   = strict ? mbe_s : mbe_a;
               acc_we[acc_n]   = strict ? mwe_s : mwe_a;
            end
            acc_n++;
         end
         if (strict ? rv_s : rv_a) begin
            obs_lat   = k;
            obs_rdata = strict ? rdata_s : rdata_a;
            obs_fault = strict ? fault_s : fault_a;
            break;
         end
         @(posedge clk); #1;
      end
      check($sformatf("latency %0h f3=%0d we=%0d", addr, f3, we), 64'(obs_lat), 64'(e_lat));
      check($sformatf("fault %0h f3=%0d we=%0d", addr, f3, we), 64'(obs_fault), 64'(e_fault));
      check($sformatf("rdata %0h f3=%0d we=%0d", addr, f3, we), 64'(obs_rdata), 64'(e_rdata));
   endtask

   task automatic check_access(input string tag, input int i, input logic [31:0] a,
                               input logic [3:0] be, input logic [31:0] wd, input logic we);
      check({tag, "_addr"}, 64'(acc_addr[i]), 64'(a));
      check({tag, "_be"},   64'(acc_be[i]),   64'(be));
      check({tag, "_wd"},   64'(acc_wd[i]),   64'(wd));
      check({tag, "_we"},   64'(acc_we[i]),   64'(we));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_mem"}, {maddr_a, mwdata_a}, 64'(0));
      check({tag, "_ctl"}, 64'({ready_a, rv_a, fault_a, mre_a, mwe_a, mbe_a, rdata_a}), 64'(0));
   endtask

   initial begin
      int s0, w0;
      logic [31:0] word24;
      for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      reset = 1'b0; mem_clear = 1'b0;
      #1;
      check("ready_after_reset", 64'(ready_a), 64'(1));

      run(0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
      check("sw_count", 64'(acc_n), 64'(1));
      check_access("sw", 0, 32'h10, 4'b1111, 32'hDEAD_BEEF, 1'b1);
      run(0, 1'b0, 3'b010, 32'h10, 32'h0);
      check("lw", 64'(obs_rdata), 64'(32'hDEAD_BEEF));

      run(0, 1'b1, 3'b010, 32'h10, 32'h8000_0000);
      run(0, 1'b0, 3'b000, 32'h13, 32'h0);
      check("lb", 64'(obs_rdata), 64'(32'hFFFF_FF80));
      run(0, 1'b0, 3'b100, 32'h13, 32'h0);
      check("lbu", 64'(obs_rdata), 64'(32'h0000_0080));
      run(0, 1'b0, 3'b001, 32'h12, 32'h0);
      check("lh", 64'(obs_rdata), 64'(32'hFFFF_8000));
      run(0, 1'b0, 3'b101, 32'h12, 32'h0);
      check("lhu", 64'(obs_rdata), 64'(32'h0000_8000));

      run(0, 1'b1, 3'b010, 32'h22, 32'h1122_3344);
      check("split_count", 64'(acc_n), 64'(2));
      check_access("split0", 0, 32'h20, 4'b1100, 32'h3344_0000, 1'b1);
      check_access("split1", 1, 32'h24, 4'b0011, 32'h0000_1122, 1'b1);
      run(0, 1'b0, 3'b010, 32'h22, 32'h0);
      check("split_lw", 64'(obs_rdata), 64'(32'h1122_3344));

      run(0, 1'b1, 3'b001, 32'h21, 32'h0000_ABCD);
      check("sh_count", 64'(acc_n), 64'(1));
      check_access("sh", 0, 32'h20, 4'b0110, 32'h00AB_CD00, 1'b1);

      run(0, 1'b1, 3'b010, 32'hFFFF_FFFE, 32'hCAFE_F00D);
      check_access("wrap0", 0, 32'hFFFF_FFFC, 4'b1100, 32'hF00D_0000, 1'b1);
      check_access("wrap1", 1, 32'h0, 4'b0011, 32'h0000_CAFE, 1'b1);
      run(0, 1'b0, 3'b110, 32'h10, 32'h0);
      check("illegal_no_access", 64'(acc_n), 64'(0));

      s0 = strobe_s;
      run(1, 1'b0, 3'b010, 32'h22, 32'h0);
      run(1, 1'b0, 3'b011, 32'h10, 32'h0);
      run(1, 1'b1, 3'b100, 32'h10, 32'h55);
      run(1, 1'b1, 3'b001, 32'h11, 32'h1234);
      check("strict_no_strobes", 64'(strobe_s), 64'(s0));

      repeat (300) begin
         logic [31:0] a;
         a = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h3F);
         run(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
      end

      w0 = wr24; word24 = mem_a[9];
      @(negedge clk);
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h22; req_wdata = 32'h1122_3344;
      req_valid_a = 1'b1;
      @(posedge clk); #1;
      req_valid_a = 1'b0;
      check("rst_acc0", 64'({mwe_a, maddr_a}), 64'({1'b1, 32'h20}));
      reset = 1'b1;
      #1;
      check("rst_gate", 64'({mwe_a, mre_a}), 64'(0));
      repeat (2) begin
         @(posedge clk); #1;
         check_all_zero("rst_hold");
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_ready", 64'(ready_a), 64'(1));
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("rst_no_resp", 64'(rv_a), 64'(0));
      end
      check("rst_no_w24", 64'(wr24), 64'(w0));
      check("rst_word24", 64'(mem_a[9]), 64'(word24));
      run(0, 1'b0, 3'b010, 32'h10, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
